// File: rtl/cronometro_ctrl_if.sv
// Button pulses into the stopwatch core and the BCD time/status toward the display stage.
interface cronometro_ctrl_if;
    logic       ApertaStart;
    logic       ApertaZera;
    logic [3:0] CentU;
    logic [3:0] CentD;
    logic [3:0] SegU;
    logic [3:0] SegD;
    logic [3:0] MinU;
    logic [3:0] MinD;
    logic       Rodando;
    logic       Estouro;

    modport master (
        output ApertaStart, ApertaZera,
        input  CentU, CentD, SegU, SegD, MinU, MinD, Rodando, Estouro
    );

    modport slave (
        input  ApertaStart, ApertaZera,
        output CentU, CentD, SegU, SegD, MinU, MinD, Rodando, Estouro
    );
endinterface

// File: rtl/cronometro_ctrl.sv
// Stopwatch core: start/pause/clear FSM, centisecond prescaler and MM:SS.CC BCD counter.
module cronometro_ctrl #(
    parameter int unsigned DIV = 500000
) (
    input  logic               CLK,
    input  logic               RST,
    cronometro_ctrl_if.slave   bus
);
    localparam int unsigned PW    = 20;
    localparam int unsigned ND    = 6;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    // Per-digit maximum, index 0 = CentU ... index 5 = MinD
    localparam logic [ND-1:0][3:0] DMAX = 24'h595999;

    typedef enum logic [2:0] {
        ZERADO  = 3'b001,
        RODANDO = 3'b010,
        PAUSADO = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [ND-1:0][3:0]    dig_q, dig_d, dig_inc;
    logic                  rodando_q, rodando_d;
    logic                  estouro_q, estouro_d;
    logic                  start_ev, zera_ev, tick, wrap;

    assign start_ev = ~bus.ApertaStart;
    assign zera_ev  = ~bus.ApertaZera;
    assign tick     = (state_q == RODANDO) && (presc_q == PMAX);

    // Ripple-carry BCD increment; carry out of MinD marks the 59:59.99 wrap
    always_comb begin : inc_chain
        logic carry;
        dig_inc = dig_q;
        carry   = tick;
        for (int i = 0; i < ND; i++) begin
            if (carry) begin
                if (dig_q[i] >= DMAX[i]) begin
                    dig_inc[i] = 4'd0;
                end else begin
                    dig_inc[i] = dig_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        dig_d     = dig_q;
        estouro_d = 1'b0;
        case (state_q)
            ZERADO: begin
                if (start_ev) state_d = RODANDO;
            end
            RODANDO: begin
                if (tick) begin
                    presc_d   = '0;
                    dig_d     = dig_inc;
                    estouro_d = wrap;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (start_ev) state_d = PAUSADO;
            end
            PAUSADO: begin
                // Clear has priority over resume when both buttons land together
                if (zera_ev) begin
                    state_d = ZERADO;
                    presc_d = '0;
                    dig_d   = '0;
                end else if (start_ev) begin
                    state_d = RODANDO;
                end
            end
            default: begin
                state_d = ZERADO;
                presc_d = '0;
                dig_d   = '0;
            end
        endcase
        rodando_d = (state_d == RODANDO);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ZERADO;
            presc_q   <= '0;
            dig_q     <= '0;
            rodando_q <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            rodando_q <= rodando_d;
            estouro_q <= estouro_d;
        end
    end

    assign bus.CentU   = dig_q[0];
    assign bus.CentD   = dig_q[1];
    assign bus.SegU    = dig_q[2];
    assign bus.SegD    = dig_q[3];
    assign bus.MinU    = dig_q[4];
    assign bus.MinD    = dig_q[5];
    assign bus.Rodando = rodando_q;
    assign bus.Estouro = estouro_q;
endmodule
